// File: rtl/tl_ul_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tl_ul_mem_responder
// Description : TileLink-UL manager for single-beat A requests. Backs Get,
//               PutFullData and PutPartialData with a word-addressed register
//               array and returns D acknowledgements through a 2-entry
//               response queue. Optional per-response wait states are enabled
//               by defining TL_RESP_WAIT_STATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_ul_mem_responder #(
  parameter int              ADDR_W      = 26,
  parameter int              SOURCE_W    = 10,
  parameter int              DEPTH       = 64,
  parameter logic [ADDR_W-1:0] BASE      = '0,
  parameter int              WAIT_CYCLES = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic [31:0]         d_data
);

  localparam int                c_idx_w   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] c_span    = ADDR_W'(4 * DEPTH);
  localparam logic [2:0]        c_op_put_full = 3'd0;
  localparam logic [2:0]        c_op_put_part = 3'd1;
  localparam logic [2:0]        c_op_get      = 3'd4;
  localparam logic [3:0]        c_wait    = 4'(WAIT_CYCLES);

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                denied;
    logic [31:0]         data;
  } rsp_t;

  logic [31:0]         r_mem [DEPTH];
  rsp_t                r_q0;
  rsp_t                r_q1;
  logic [1:0]          r_cnt;

  logic [ADDR_W-1:0]   w_off;
  logic [c_idx_w-1:0]  w_idx;
  logic                w_hit;
  logic                w_aligned;
  logic                w_op_ok;
  logic                w_ok;
  logic                w_fire;
  logic                w_enq;
  logic                w_deq;
  logic                w_wr;
  logic [31:0]         w_lane_mask;
  rsp_t                w_new;

  assign a_ready = reset_n & (r_cnt < 2'd2);
  assign w_fire  = a_valid & a_ready;
  assign w_enq   = w_fire;
  assign w_deq   = d_valid & d_ready;

  // Subtraction wraps in ADDR_W bits, so addresses below BASE land far out of range.
  assign w_off   = a_address - BASE;
  assign w_idx   = w_off[c_idx_w+1:2];
  assign w_hit   = (w_off < c_span);
  assign w_op_ok = (a_opcode == c_op_put_full) | (a_opcode == c_op_put_part) |
                   (a_opcode == c_op_get);
  assign w_ok    = w_hit & w_aligned & (a_size <= 2'd2) & w_op_ok;
  assign w_wr    = w_fire & w_ok & (a_opcode != c_op_get);

  assign w_lane_mask = {{8{a_mask[3]}}, {8{a_mask[2]}}, {8{a_mask[1]}}, {8{a_mask[0]}}};

  // Alignment check and response formation for the request on the A channel.
  always_comb begin
    w_aligned = 1'b0;
    case (a_size)
      2'd0:    w_aligned = 1'b1;
      2'd1:    w_aligned = ~a_address[0];
      2'd2:    w_aligned = (a_address[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
    w_new        = '0;
    w_new.opcode = ((a_opcode == c_op_put_full) || (a_opcode == c_op_put_part)) ? 3'd0 : 3'd1;
    w_new.size   = a_size;
    w_new.source = a_source;
    w_new.denied = ~w_ok;
    if (w_ok && (a_opcode == c_op_get)) begin
      w_new.data = r_mem[w_idx] & w_lane_mask;
    end
  end

  // Byte-lane writes commit at the Put's fire edge; the array is never reset.
  always_ff @(posedge clock) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= a_data[8*b +: 8];
        end
      end
    end
  end

  // Two-entry response queue; r_q0 is the head and drives D directly.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= 2'd0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else begin
      case ({w_enq, w_deq})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_q0 <= w_new;
          end else begin
            r_q1 <= w_new;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0 <= w_new;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= w_new;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef TL_RESP_WAIT_STATE_EN
  logic [3:0] r_wait;
  logic       w_new_head;
  logic       w_unused;

  assign w_new_head = (w_enq & ((r_cnt == 2'd0) | (w_deq & (r_cnt == 2'd1)))) |
                      (w_deq & (r_cnt == 2'd2));
  assign w_unused   = ^a_param;

  // Wait counter reloads when a new entry reaches the head and keeps
  // counting regardless of d_ready.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wait <= 4'd0;
    end else if (w_new_head) begin
      r_wait <= c_wait;
    end else if ((r_cnt != 2'd0) && (r_wait != 4'd0)) begin
      r_wait <= r_wait - 4'd1;
    end
  end

  assign d_valid = (r_cnt != 2'd0) & (r_wait == 4'd0);
`else
  logic w_unused;

  assign w_unused = ^{a_param, c_wait};
  assign d_valid  = (r_cnt != 2'd0);
`endif

  assign d_opcode = r_q0.opcode;
  assign d_param  = 2'b00;
  assign d_size   = r_q0.size;
  assign d_source = r_q0.source;
  assign d_denied = r_q0.denied;
  assign d_data   = r_q0.data;

endmodule
`default_nettype wire

// File: tb/tb_tl_ul_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_ul_mem_responder
// Description : Scoreboard bench for tl_ul_mem_responder. Directed cases
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_ul_mem_responder;

  localparam int          ADDR_W      = 26;
  localparam int          SOURCE_W    = 10;
  localparam int          DEPTH       = 64;
  localparam int          WAIT_CYCLES = 3;
  localparam logic [25:0] BASE        = 26'h0001000;
`ifdef TL_RESP_WAIT_STATE_EN
  localparam int          LAT = 1 + WAIT_CYCLES;
`else
  localparam int          LAT = 1;
`endif

  logic                clock;
  logic                reset_n;
  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [1:0]          a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic [3:0]          a_mask;
  logic [31:0]         a_data;
  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [1:0]          d_size;
  logic [SOURCE_W-1:0] d_source;
  logic                d_denied;
  logic [31:0]         d_data;

  tl_ul_mem_responder #(
    .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W), .DEPTH(DEPTH),
    .BASE(BASE), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_data(d_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [9:0]  src;
    logic        den;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] mdl_mem [DEPTH];
  int          n_total = 0;
  int          n_bad   = 0;
  bit          rnd_ready = 1'b0;

  // Reference model: derive the response from the protocol rules and apply writes.
  task automatic expect_req(input logic [2:0] op, input logic [1:0] size,
                            input logic [9:0] src, input logic [25:0] addr,
                            input logic [3:0] mask, input logic [31:0] data);
    rsp_t   e;
    longint off;
    int     idx;
    bit     ok;
    off = longint'(addr) - longint'(BASE);
    if (off < 0) off = off + (longint'(1) << 26);
    ok  = (off < 4 * DEPTH) && (size <= 2) && ((int'(addr) % (1 << size)) == 0) &&
          (op == 3'd0 || op == 3'd1 || op == 3'd4);
    idx = int'(off / 4);
    e.op   = (op == 3'd0 || op == 3'd1) ? 3'd0 : 3'd1;
    e.size = size;
    e.src  = src;
    e.den  = !ok;
    e.data = 32'h0;
    if (ok) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) begin
          if (op == 3'd4) e.data[8*b +: 8] = mdl_mem[idx][8*b +: 8];
          else            mdl_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Entered and left at posedge+1; holds the request until it is accepted.
  task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [9:0] src,
                      input logic [25:0] addr, input logic [3:0] mask, input logic [31:0] data);
    int guard = 0;
    a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_param = 3'($urandom);
    forever begin
      @(negedge clock);
      if (a_ready) begin
        expect_req(op, size, src, addr, mask, data);
        @(posedge clock); #1;
        a_valid = 1'b0;
        if (rnd_ready) d_ready = ($urandom % 4) != 0;
        break;
      end
      guard++;
      if (guard > 200) begin
        n_total++; n_bad++;
        $display("FAIL accept_timeout: a_ready stayed 0, required 1 within 200 cycles");
        @(posedge clock); #1;
        a_valid = 1'b0;
        break;
      end
      @(posedge clock); #1;
      if (rnd_ready) d_ready = ($urandom % 4) != 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      if (rnd_ready) d_ready = ($urandom % 4) != 0;
    end
  endtask

  task automatic drain();
    int guard = 0;
    rnd_ready = 1'b0;
    d_ready   = 1'b1;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    n_total++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clock); #1;
  endtask

  // Monitor: pop and compare on every D handshake, and hold stalled beats stable.
  rsp_t held;
  bit   stalled = 1'b0;
  always @(negedge clock) begin
    rsp_t e;
    if (!reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        n_total++;
        if (!d_valid || d_opcode !== held.op || d_size !== held.size ||
            d_source !== held.src || d_denied !== held.den || d_data !== held.data) begin
          n_bad++;
          $display("FAIL hold: valid=%0b op=%0d src=%0h data=%0h, required valid=1 op=%0d src=%0h data=%0h",
                   d_valid, d_opcode, d_source, d_data, held.op, held.src, held.data);
        end
      end
      stalled = 1'b0;
      if (d_valid) begin
        if (d_ready) begin
          n_total++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected: d_valid with src=%0h, nothing outstanding", d_source);
          end else begin
            e = sb.pop_front();
            if (d_opcode !== e.op || d_size !== e.size || d_source !== e.src ||
                d_denied !== e.den || d_data !== e.data || d_param !== 2'd0) begin
              n_bad++;
              $display("FAIL rsp: got op=%0d size=%0d src=%0h den=%0b data=%0h param=%0d, required op=%0d size=%0d src=%0h den=%0b data=%0h param=0",
                       d_opcode, d_size, d_source, d_denied, d_data, d_param,
                       e.op, e.size, e.src, e.den, e.data);
            end
          end
        end else begin
          stalled = 1'b1;
          held.op = d_opcode; held.size = d_size; held.src = d_source;
          held.den = d_denied; held.data = d_data;
        end
      end
    end
  end

  initial begin
    int          n;
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [25:0] addr;
    int          r;

    reset_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
    a_source = '0; a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b0;

    // Reset then idle.
    @(negedge clock);
    check("a_ready_in_reset", 32'(a_ready), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_fields", {d_opcode, d_param, d_size, d_denied, d_source}, 32'd0);
    check("rst_d_data", d_data, 32'd0);
    @(posedge clock); #1;

    // Give every word a known value.
    d_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      send(3'd0, 2'd2, 10'(i), BASE + 26'(4 * i), 4'hF, $urandom);
    end
    drain();

    // Single Get latency from fire to first d_valid.
    send(3'd4, 2'd2, 10'h3F, BASE + 26'd20, 4'hF, 32'h0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!d_valid && n < 20);
    check("latency", 32'(n), 32'(LAT));
    @(posedge clock); #1;
    drain();

    // PutFull then Get, then PutPartial then Get.
    send(3'd0, 2'd2, 10'h3, BASE + 26'd8, 4'hF, 32'hDEADBEEF);
    send(3'd4, 2'd2, 10'h7, BASE + 26'd8, 4'hF, 32'h0);
    send(3'd1, 2'd2, 10'h4, BASE + 26'd8, 4'b0010, 32'h0000AA00);
    send(3'd4, 2'd2, 10'h8, BASE + 26'd8, 4'hF, 32'h0);
    drain();

    // Backpressure: queue fills after two accepts, head stays stable.
    d_ready = 1'b0;
    send(3'd4, 2'd2, 10'h1, BASE + 26'd8, 4'hF, 32'h0);
    send(3'd4, 2'd2, 10'h2, BASE + 26'd12, 4'hF, 32'h0);
    @(negedge clock);
    check("a_ready_full", 32'(a_ready), 32'd0);
    repeat (LAT + 3) @(negedge clock);
    check("bp_head_src", {21'd0, d_valid, d_source}, {21'd0, 1'b1, 10'h1});
    @(posedge clock); #1;
    d_ready = 1'b1;
    send(3'd4, 2'd2, 10'h3, BASE + 26'd16, 4'hF, 32'h0);
    drain();

    // Denied requests: out of range, misaligned, unsupported opcode, below BASE.
    send(3'd4, 2'd2, 10'h11, BASE + 26'(4 * DEPTH), 4'hF, 32'h0);
    send(3'd4, 2'd2, 10'h12, BASE + 26'd2, 4'hF, 32'h0);
    send(3'd2, 2'd2, 10'h13, BASE + 26'd16, 4'hF, 32'h0);
    send(3'd0, 2'd2, 10'h14, BASE - 26'd4, 4'hF, 32'h12345678);
    send(3'd4, 2'd3, 10'h15, BASE, 4'hF, 32'h0);
    drain();

    // Reset with responses queued discards them.
    d_ready = 1'b0;
    send(3'd4, 2'd2, 10'h21, BASE, 4'hF, 32'h0);
    send(3'd4, 2'd2, 10'h22, BASE + 26'd4, 4'hF, 32'h0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    sb.delete();
    @(negedge clock);
    check("mid_rst_d_valid", 32'(d_valid), 32'd0);
    check("mid_rst_a_ready", 32'(a_ready), 32'd1);
    @(posedge clock); #1;
    d_ready = 1'b1;
    idle(LAT + 3);

    // Randomized traffic with random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom % 10);
      if (r < 3)      op = 3'd0;
      else if (r < 5) op = 3'd1;
      else if (r < 9) op = 3'd4;
      else begin
        r = int'($urandom % 5);
        op = (r == 0) ? 3'd2 : (r == 1) ? 3'd3 : 3'(r + 3);
      end
      sz = (($urandom % 4) == 0) ? 2'($urandom) : 2'd2;
      r  = int'($urandom % 10);
      if (r == 0)      addr = BASE + 26'(4 * DEPTH) + 26'($urandom % 64);
      else if (r == 1) addr = BASE - 26'(1 + $urandom % 64);
      else             addr = BASE + 26'(4 * ($urandom % DEPTH)) + 26'($urandom % 4);
      send(op, sz, 10'($urandom), addr, 4'($urandom), $urandom);
      if (($urandom % 4) == 0) idle(1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
